// File: rtl/pwm_channel_bank_pkg.sv
// pwm_channel_bank_pkg: shared sizes and per-channel select codes for the PWM channel bank
//   NCH   number of channels covered by the select-code table
//   DW    width of period/duty registers and write data
//   SW    width of the decoder select code
//   E_/T_/D_CODE  enable / period-shadow / duty-shadow write codes, indexed by channel
package pwm_channel_bank_pkg;
  localparam int NCH = 8;
  localparam int DW = 16;
  localparam int SW = 7;
  localparam logic [NCH-1:0][SW-1:0] E_CODE = {7'h28, 7'h0D, 7'h15, 7'h06, 7'h0A, 7'h1C, 7'h08, 7'h01};
  localparam logic [NCH-1:0][SW-1:0] T_CODE = {7'h22, 7'h26, 7'h1B, 7'h0C, 7'h1F, 7'h18, 7'h10, 7'h02};
  localparam logic [NCH-1:0][SW-1:0] D_CODE = {7'h24, 7'h25, 7'h05, 7'h1A, 7'h0F, 7'h0E, 7'h1E, 7'h04};
endpackage

// File: rtl/pwm_channel_bank_channel.sv
// pwm_channel_bank_channel: one PWM generator with active period/duty reloaded from shadows at wrap
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_en                  channel enable
//   i_tsh, i_dsh          shadow period / duty
//   i_tick                shared prescaler tick
//   o_pwm                 registered PWM output
//   o_period_end          registered pulse in the cycle the counter restarts at 0
module pwm_channel_bank_channel #(
  parameter int DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_tsh,
  input  logic [DW-1:0] i_dsh,
  input  logic          i_tick,
  output logic          o_pwm,
  output logic          o_period_end
);
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] r_tact;
  logic [DW-1:0] r_dact;
  logic          r_pwm;
  logic          r_pe;
  logic          w_tz;
  logic          w_wrap;
  assign w_tz = r_tact == '0;
  // a zero period wraps every tick so a new shadow period can still be picked up
  assign w_wrap = w_tz || r_cnt == r_tact - 1'b1;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tact <= '0;
      r_dact <= '0;
      r_pwm  <= 1'b0;
      r_pe   <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tact <= i_tsh;
      r_dact <= i_dsh;
      r_pwm  <= 1'b0;
      r_pe   <= 1'b0;
    end else begin
      r_pwm <= !w_tz && r_cnt < r_dact;
      r_pe  <= i_tick && w_wrap && !w_tz;
      if (i_tick) begin
        r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
        r_tact <= w_wrap ? i_tsh : r_tact;
        r_dact <= w_wrap ? i_dsh : r_dact;
      end
    end
  end
  assign o_pwm = r_pwm;
  assign o_period_end = r_pe;
endmodule

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: select-code decode, enable/shadow registers, shared prescaler and NCH PWM channels
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_s              decoder select code, 0 = no write
//   i_d_in           write data
//   o_pwm_out        registered PWM outputs, one per channel
//   o_period_end     one-cycle pulse per channel when its counter wraps
module pwm_channel_bank #(
  parameter int DW = pwm_channel_bank_pkg::DW,
  parameter int PRESC = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [pwm_channel_bank_pkg::SW-1:0]   i_s,
  input  logic [DW-1:0]                         i_d_in,
  output logic [pwm_channel_bank_pkg::NCH-1:0]  o_pwm_out,
  output logic [pwm_channel_bank_pkg::NCH-1:0]  o_period_end
);
  import pwm_channel_bank_pkg::*;
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);
  logic [NCH-1:0]         r_en;
  logic [NCH-1:0][DW-1:0] r_tsh;
  logic [NCH-1:0][DW-1:0] r_dsh;
  logic [PW-1:0]          r_psc;
  logic                   w_tick;
  assign w_tick = r_psc == PMAX;
  // no code in the table is zero, so s == 0 never matches and unlisted codes fall through
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_en  <= '0;
      r_tsh <= '0;
      r_dsh <= '0;
      r_psc <= '0;
    end else begin
      r_psc <= w_tick ? '0 : r_psc + 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (i_s == E_CODE[c]) r_en[c] <= i_d_in[0];
        if (i_s == T_CODE[c]) r_tsh[c] <= i_d_in;
        if (i_s == D_CODE[c]) r_dsh[c] <= i_d_in;
      end
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pwm_channel_bank_channel #(.DW(DW)) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (r_en[c]),
      .i_tsh       (r_tsh[c]),
      .i_dsh       (r_dsh[c]),
      .i_tick      (w_tick),
      .o_pwm       (o_pwm_out[c]),
      .o_period_end(o_period_end[c])
    );
  end
endmodule
